// File: rtl/gate_share_arb_pkg.sv
// Shared types and helpers for gate_share_arb.
package gate_share_arb_pkg;

  localparam int unsigned NREQ_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Settle counter width; it must hold SETTLE-1.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle + 1) : 1;
  endfunction

  // Requester index width.
  function automatic int unsigned idx_width(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/gate_share_arb_if.sv
// Requester-side bus of gate_share_arb: requests, operands, grant/done strobes, result.
interface gate_share_arb_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] x_in;
  logic [NREQ-1:0] y_in;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            z_out;
  logic            busy;
  logic            err;

  modport master (
    output req, x_in, y_in,
    input  gnt, done, z_out, busy, err
  );

  modport slave (
    input  req, x_in, y_in,
    output gnt, done, z_out, busy, err
  );
endinterface

// File: rtl/gate_share_arb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_last wins.
module rr_pick
  import gate_share_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  // Walk last+1 .. last+NREQ modulo NREQ and take the first active request.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = IW'((32'(i_last) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/gate_share_arb.sv
// Round-robin arbiter sharing one external 2-input AND gate among NREQ requesters.
// Optional result checker enabled by defining GATE_SHARE_ARB_CHECK_EN.
module gate_share_arb
  import gate_share_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_share_arb_if.slave       bus,
  output logic                  gate_x,
  output logic                  gate_y,
  input  logic                  gate_z
);

  localparam int unsigned IW = idx_width(NREQ);
  localparam int unsigned CW = cnt_width(SETTLE);

  state_e          r_state;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_z_out;
  logic            r_busy;
  logic            r_gate_x;
  logic            r_gate_y;

  logic [NREQ-1:0] w_onehot;
  logic [IW-1:0]   w_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  // Transaction FSM: grant and latch operands, hold for SETTLE cycles, sample, strobe done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last   <= IW'(NREQ - 1);
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_z_out  <= 1'b0;
      r_busy   <= 1'b0;
      r_gate_x <= 1'b0;
      r_gate_y <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.req) begin
            r_gate_x <= bus.x_in[w_idx];
            r_gate_y <= bus.y_in[w_idx];
            r_gnt    <= w_onehot;
            r_cnt    <= CW'(SETTLE - 1);
            r_last   <= w_idx;
            r_busy   <= 1'b1;
            r_state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_gnt <= '0;
          if (r_cnt == '0) begin
            r_z_out <= gate_z;
            r_done  <= NREQ'(1) << r_last;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.done  = r_done;
  assign bus.z_out = r_z_out;
  assign bus.busy  = r_busy;
  assign gate_x    = r_gate_x;
  assign gate_y    = r_gate_y;

`ifdef GATE_SHARE_ARB_CHECK_EN
  logic r_err;
  logic w_sample;

  assign w_sample = (r_state == ST_HOLD) && (r_cnt == '0);

  // Sticky flag: gate output disagrees with the AND of the operands it was given.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_sample && (gate_z != (r_gate_x & r_gate_y))) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_gate_share_arb.sv
// Directed bench for gate_share_arb: one instance with SETTLE=1, one with SETTLE=3.
module tb_gate_share_arb;

`ifdef GATE_SHARE_ARB_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic g1_x, g1_y, g1_z, force1;
  logic g3_x, g3_y, g3_z;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  gate_share_arb_if #(.NREQ(4)) bus1 ();
  gate_share_arb_if #(.NREQ(4)) bus3 ();

  gate_share_arb #(.NREQ(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .gate_x(g1_x), .gate_y(g1_y), .gate_z(g1_z)
  );

  gate_share_arb #(.NREQ(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .gate_x(g3_x), .gate_y(g3_y), .gate_z(g3_z)
  );

  // Stand-ins for the shared andMod gates; force1 breaks the first one.
  assign g1_z = force1 ? 1'b0 : (g1_x & g1_y);
  assign g3_z = g3_x & g3_y;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          exp_z[5] = '{0, 1, 0, 1, 0};
  logic [3:0]  exp_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    force1    = 1'b0;
    bus1.req  = 4'b1111; bus1.x_in = 4'b1111; bus1.y_in = 4'b1111;
    bus3.req  = 4'b1111; bus3.x_in = 4'b1111; bus3.y_in = 4'b1111;

    // 1. reset held 3 cycles with all requests high
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_d1", 32'({bus1.gnt, bus1.done, bus1.z_out, bus1.busy, g1_x, g1_y, bus1.err}), 32'h0);
      chk("rst_d3", 32'({bus3.gnt, bus3.done, bus3.z_out, bus3.busy, g3_x, g3_y, bus3.err}), 32'h0);
    end
    bus1.req = 4'b0000; bus3.req = 4'b0000;
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(bus1.busy), 32'h0);

    // 2. single request from requester 2, x=1 y=1
    bus1.req = 4'b0100; bus1.x_in = 4'b0100; bus1.y_in = 4'b0100;
    step();
    chk("s1_gnt", 32'(bus1.gnt), 32'h4);
    chk("s1_busy_gx_gy", 32'({bus1.busy, g1_x, g1_y}), 32'h7);
    step();
    chk("s1_gnt_clr", 32'(bus1.gnt), 32'h0);
    chk("s1_done", 32'(bus1.done), 32'h4);
    chk("s1_z", 32'(bus1.z_out), 32'h1);
    bus1.req = 4'b0000;
    step();
    chk("s1_done_clr", 32'({bus1.done, bus1.busy}), 32'h0);

    // 2b. requester 2 again, x=1 y=0
    bus1.req = 4'b0100; bus1.x_in = 4'b0100; bus1.y_in = 4'b0000;
    step();
    chk("s2_gnt", 32'(bus1.gnt), 32'h4);
    step();
    chk("s2_done", 32'(bus1.done), 32'h4);
    chk("s2_z", 32'(bus1.z_out), 32'h0);
    bus1.req = 4'b0000;
    step();

    // reset so the rotation starts at requester 0
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 3. full contention, x=1011 y=1110
    bus1.req = 4'b1111; bus1.x_in = 4'b1011; bus1.y_in = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("c%0d_gnt", k), 32'(bus1.gnt), 32'(exp_g[k]));
      step();
      chk($sformatf("c%0d_done", k), 32'(bus1.done), 32'(exp_g[k]));
      chk($sformatf("c%0d_z", k), 32'(bus1.z_out), 32'(exp_z[k]));
      step();
      chk($sformatf("c%0d_gap", k), 32'({bus1.gnt, bus1.done}), 32'h0);
    end
    bus1.req = 4'b0000;
    step();

    // 4. SETTLE=3, operand changes after grant are ignored
    bus3.req = 4'b0001; bus3.x_in = 4'b0001; bus3.y_in = 4'b0001;
    step();
    chk("h_gnt", 32'(bus3.gnt), 32'h1);
    chk("h_gx", 32'(g3_x), 32'h1);
    bus3.x_in = 4'b0000;
    step();
    chk("h_t1", 32'({bus3.gnt, bus3.done, g3_x}), 32'h1);
    step();
    chk("h_t2", 32'({bus3.done, g3_x}), 32'h1);
    step();
    chk("h_done", 32'(bus3.done), 32'h1);
    chk("h_z", 32'(bus3.z_out), 32'h1);
    chk("h_gx_hold", 32'(g3_x), 32'h1);
    bus3.req = 4'b0000;
    step();
    chk("h_end", 32'({bus3.done, bus3.busy}), 32'h0);

    // 5. reset during HOLD aborts without done; rotation pointer restarts
    bus1.req = 4'b1111; bus1.x_in = 4'b1111; bus1.y_in = 4'b1111;
    step();
    chk("r_gnt", 32'(bus1.gnt), 32'h2);
    rst = 1'b1;
    step();
    chk("r_abort", 32'({bus1.gnt, bus1.done, bus1.busy}), 32'h0);
    rst = 1'b0;
    step();
    chk("r_regrant", 32'(bus1.gnt), 32'h1);
    step();
    chk("r_done", 32'(bus1.done), 32'h1);
    bus1.req = 4'b0000;
    step();

    // 6. broken gate: output 0 for operands 1,1
    force1   = 1'b1;
    bus1.req = 4'b0001; bus1.x_in = 4'b0001; bus1.y_in = 4'b0001;
    step();
    chk("e_pre", 32'(bus1.err), 32'h0);
    step();
    chk("e_z", 32'(bus1.z_out), 32'h0);
    chk("e_set", 32'(bus1.err), 32'(CHECK_EN));
    bus1.req = 4'b0000;
    force1   = 1'b0;
    step();
    step();
    chk("e_sticky", 32'(bus1.err), 32'(CHECK_EN));
    chk("e_d3_clean", 32'(bus3.err), 32'h0);
    rst = 1'b1;
    step();
    chk("e_rst", 32'(bus1.err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
